// File: rtl/imm_encoder_pipe.sv
// Two-stage RV32I immediate encoder: scatters a signed immediate into an instruction template
// and flags values that the selected immediate format cannot represent.
module imm_encoder_pipe #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [31:0]      i_inst,
    input  logic [2:0]       i_imm_type,
    input  logic [31:0]      i_imm,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [31:0]      o_inst,
    output logic             o_err,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_err_cnt
);

    localparam logic [2:0] IMM_TYPE_I = 3'd0;
    localparam logic [2:0] IMM_TYPE_S = 3'd1;
    localparam logic [2:0] IMM_TYPE_B = 3'd2;
    localparam logic [2:0] IMM_TYPE_U = 3'd3;
    localparam logic [2:0] IMM_TYPE_J = 3'd4;

    // Returns 1 when imm cannot be encoded for this type, or the type code is unknown.
    function automatic logic imm_out_of_range(input logic [2:0] imm_type,
                                              input logic signed [31:0] imm);
        logic err;
        err = 1'b0;
        case (imm_type)
            IMM_TYPE_I, IMM_TYPE_S:
                err = (imm < -32'sd2048) || (imm > 32'sd2047);
            IMM_TYPE_B:
                err = (imm < -32'sd4096) || (imm > 32'sd4094) || imm[0];
            IMM_TYPE_U:
                err = (imm[11:0] != 12'd0);
            IMM_TYPE_J:
                err = (imm < -32'sd1048576) || (imm > 32'sd1048574) || imm[0];
            default:
                err = 1'b1;
        endcase
        return err;
    endfunction

    // Overwrites the immediate field of the template; out-of-range values are truncated.
    function automatic logic [31:0] pack_imm(input logic [2:0]  imm_type,
                                             input logic [31:0] inst,
                                             input logic signed [31:0] imm);
        logic [31:0] res;
        res = inst;
        case (imm_type)
            IMM_TYPE_I: begin
                res[31:20] = imm[11:0];
            end
            IMM_TYPE_S: begin
                res[31:25] = imm[11:5];
                res[11:7]  = imm[4:0];
            end
            IMM_TYPE_B: begin
                res[31]    = imm[12];
                res[30:25] = imm[10:5];
                res[11:8]  = imm[4:1];
                res[7]     = imm[11];
            end
            IMM_TYPE_U: begin
                res[31:12] = imm[31:12];
            end
            IMM_TYPE_J: begin
                res[31]    = imm[20];
                res[30:21] = imm[10:1];
                res[20]    = imm[11];
                res[19:12] = imm[19:12];
            end
            default: begin
                res = inst;
            end
        endcase
        return res;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        logic [CNT_W-1:0] res;
        if (&cnt) begin
            res = cnt;
        end else begin
            res = cnt + 1'b1;
        end
        return res;
    endfunction

    logic                vld_p1;
    logic [31:0]         inst_p1;
    logic [2:0]          type_p1;
    logic signed [31:0]  imm_p1;
    logic                err_p1;

    logic                vld_p2;
    logic [31:0]         inst_p2;
    logic                err_p2;
    logic [CNT_W-1:0]    err_cnt;

    logic                in_xfer;
    logic                out_xfer;
    logic                adv_p2;

    assign out_xfer = vld_p2 && i_ready;
    assign adv_p2   = vld_p1 && (!vld_p2 || i_ready);
    // No skid buffer: input readiness depends combinationally on downstream i_ready.
    assign o_ready  = !vld_p1 || adv_p2;
    assign in_xfer  = i_valid && o_ready;

    // ---- Stage 1: capture template, type, immediate and range-check result ----
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_p1 <= 1'b0;
        end else if (in_xfer) begin
            vld_p1 <= 1'b1;
        end else if (adv_p2) begin
            vld_p1 <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (in_xfer) begin
            inst_p1 <= i_inst;
            type_p1 <= i_imm_type;
            imm_p1  <= i_imm;
            err_p1  <= imm_out_of_range(i_imm_type, i_imm);
        end
    end

    // ---- Stage 2: merged instruction and error flag, held while stalled ----
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_p2  <= 1'b0;
            inst_p2 <= 32'd0;
            err_p2  <= 1'b0;
        end else if (adv_p2) begin
            vld_p2  <= 1'b1;
            inst_p2 <= pack_imm(type_p1, inst_p1, imm_p1);
            err_p2  <= err_p1;
        end else if (out_xfer) begin
            vld_p2  <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err_cnt <= '0;
        end else if (i_clr) begin
            err_cnt <= '0;
        end else if (out_xfer && err_p2) begin
            err_cnt <= sat_inc(err_cnt);
        end
    end

    assign o_valid   = vld_p2;
    assign o_inst    = inst_p2;
    assign o_err     = err_p2;
    assign o_err_cnt = err_cnt;

endmodule
